// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM encoding and
// the bit order of the packed pipeline control vector.
package pipeline_hazard_controller_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  // Control vector order {freezePC, freezeIF2ID, freezeID2EXE, freezeEXE2MEM,
  // freezeMEM2WB, flushIF2ID, flushID2EXE}; the pipeline-register top reuses it.
  localparam int CTL_W             = 7;
  localparam int CTL_FREEZE_PC     = 6;
  localparam int CTL_FREEZE_IF2ID  = 5;
  localparam int CTL_FREEZE_ID2EXE = 4;
  localparam int CTL_FREEZE_EXE2MEM = 3;
  localparam int CTL_FREEZE_MEM2WB = 2;
  localparam int CTL_FLUSH_IF2ID   = 1;
  localparam int CTL_FLUSH_ID2EXE  = 0;

  typedef logic [CTL_W-1:0] ctl_t;

  function automatic ctl_t ctl_freeze_all();
    ctl_t c;
    c = '0;
    c[CTL_FREEZE_PC]      = 1'b1;
    c[CTL_FREEZE_IF2ID]   = 1'b1;
    c[CTL_FREEZE_ID2EXE]  = 1'b1;
    c[CTL_FREEZE_EXE2MEM] = 1'b1;
    c[CTL_FREEZE_MEM2WB]  = 1'b1;
    return c;
  endfunction

  function automatic ctl_t ctl_flush_front();
    ctl_t c;
    c = '0;
    c[CTL_FLUSH_IF2ID]  = 1'b1;
    c[CTL_FLUSH_ID2EXE] = 1'b1;
    return c;
  endfunction

  function automatic ctl_t ctl_bubble();
    ctl_t c;
    c = '0;
    c[CTL_FREEZE_PC]    = 1'b1;
    c[CTL_FREEZE_IF2ID] = 1'b1;
    c[CTL_FLUSH_ID2EXE] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous active-high clear; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait > taken branch >
// ID hazard, with a memory-wait watchdog and saturating perf counters.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hazardIn,
  input  logic                 branchTakenIn,
  input  logic                 memAccessIn,
  input  logic                 memReadyIn,
  output logic                 freezePC,
  output logic                 freezeIF2ID,
  output logic                 freezeID2EXE,
  output logic                 freezeEXE2MEM,
  output logic                 freezeMEM2WB,
  output logic                 flushIF2ID,
  output logic                 flushID2EXE,
  output logic                 memTimeout,
  output logic [CNT_WIDTH-1:0] stallCycles,
  output logic [CNT_WIDTH-1:0] branchFlushes
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic           timeout_q, timeout_d;
  ctl_t           ctl;
  logic           br_evt;

  always_comb begin
    ctl       = '0;
    br_evt    = 1'b0;
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    if (rst) begin
      ctl = ctl_flush_front();
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (memAccessIn && !memReadyIn) begin
            ctl     = ctl_freeze_all();
            state_d = ST_MEM_WAIT;
            wait_d  = WCW'(1);
          end else if (branchTakenIn) begin
            // A coincident hazard belongs to an instruction being flushed.
            ctl    = ctl_flush_front();
            br_evt = 1'b1;
          end else if (hazardIn) begin
            ctl = ctl_bubble();
          end
        end
        ST_MEM_WAIT: begin
          ctl = ctl_freeze_all();
          // A dropped access is treated as a completed one.
          if (memReadyIn || !memAccessIn) begin
            state_d = ST_RUN;
            wait_d  = '0;
          end else if (wait_q == WAIT_LAST) begin
            state_d   = ST_RUN;
            wait_d    = '0;
            timeout_d = 1'b1;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_RUN;
          wait_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctl[CTL_FREEZE_PC]),
    .count (stallCycles)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (br_evt),
    .count (branchFlushes)
  );

  assign freezePC      = ctl[CTL_FREEZE_PC];
  assign freezeIF2ID   = ctl[CTL_FREEZE_IF2ID];
  assign freezeID2EXE  = ctl[CTL_FREEZE_ID2EXE];
  assign freezeEXE2MEM = ctl[CTL_FREEZE_EXE2MEM];
  assign freezeMEM2WB  = ctl[CTL_FREEZE_MEM2WB];
  assign flushIF2ID    = ctl[CTL_FLUSH_IF2ID];
  assign flushID2EXE   = ctl[CTL_FLUSH_ID2EXE];
  assign memTimeout    = timeout_q;

endmodule
